// File: rtl/addsub_pkg.sv
// Shared constants and types for the sequential add/subtract unit.
package addsub_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Number of slice cycles needed for one full-width operation.
  function automatic int num_slices(input int width, input int slice);
    return width / slice;
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// Combinational SLICE-bit ripple adder/subtractor. Also reports the carry
// into the slice MSB so the top can derive signed overflow on the last slice.
module addsub_slice
  import addsub_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  input  logic             cin_i,
  input  logic             mode_i,
  output logic [SLICE-1:0] result_o,
  output logic             cout_o,
  output logic             c_msb_in_o
);

  // Ripple the carry (add) or borrow (sub) across the slice bits.
  always_comb begin
    logic c;
    c          = cin_i;
    result_o   = '0;
    c_msb_in_o = 1'b0;
    for (int i = 0; i < SLICE; i++) begin
      if (i == SLICE - 1) c_msb_in_o = c;
      result_o[i] = a_i[i] ^ b_i[i] ^ c;
      if (mode_i == MODE_SUB)
        c = (~a_i[i] & (b_i[i] | c)) | (b_i[i] & c);
      else
        c = (a_i[i] & b_i[i]) | (a_i[i] & c) | (b_i[i] & c);
    end
    cout_o = c;
  end

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle add/subtract unit: SLICE bits per clock, LSB slice first, with
// the carry/borrow registered between slices. Results are published only on
// the final slice edge, together with a one-cycle DONE pulse.
//
//   state | meaning
//   IDLE  | waiting for START; outputs hold the last result
//   RUN   | one slice processed per edge; last slice publishes the result
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SLICE = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             MODE,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_we,
  output logic [WIDTH-1:0] Q,
  output logic             C_wy,
  output logic             OVF,
  output logic             Z,
  output logic             BUSY,
  output logic             DONE
);

  localparam int N     = num_slices(WIDTH, SLICE);
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  if ((WIDTH % SLICE) != 0) begin : g_bad_width
    $error("addsub_seq: WIDTH must be a multiple of SLICE");
  end

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             mode_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [WIDTH-1:0] a_d, b_d, res_d;
  logic [WIDTH-1:0] q_q;
  logic             cy_q, ovf_q, z_q, busy_q, done_q;

  logic [SLICE-1:0] slice_res;
  logic             slice_cout;
  logic             slice_cmsb;

  // Operands shift right so the active slice is always the low SLICE bits;
  // results shift in from the top so the first slice ends up at the LSB.
  addsub_slice #(.SLICE(SLICE)) u_slice (
    .a_i        (a_q[SLICE-1:0]),
    .b_i        (b_q[SLICE-1:0]),
    .cin_i      (carry_q),
    .mode_i     (mode_q),
    .result_o   (slice_res),
    .cout_o     (slice_cout),
    .c_msb_in_o (slice_cmsb)
  );

  if (N == 1) begin : g_single
    // Single slice covers the whole word; nothing to shift.
    always_comb begin
      a_d   = a_q;
      b_d   = b_q;
      res_d = slice_res;
    end
  end else begin : g_multi
    // Advance operands and accumulate the result by one slice.
    always_comb begin
      a_d   = {{SLICE{1'b0}}, a_q[WIDTH-1:SLICE]};
      b_d   = {{SLICE{1'b0}}, b_q[WIDTH-1:SLICE]};
      res_d = {slice_res, res_q[WIDTH-1:SLICE]};
    end
  end

  // Control FSM, slice counter, datapath and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      mode_q  <= MODE_ADD;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      q_q     <= '0;
      cy_q    <= 1'b0;
      ovf_q   <= 1'b0;
      z_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (START) begin
            state_q <= RUN;
            a_q     <= A;
            b_q     <= B;
            mode_q  <= MODE;
            carry_q <= C_we;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          a_q     <= a_d;
          b_q     <= b_d;
          res_q   <= res_d;
          carry_q <= slice_cout;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            q_q     <= res_d;
            cy_q    <= slice_cout;
            ovf_q   <= slice_cmsb ^ slice_cout;
            z_q     <= (res_d == '0);
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Q    = q_q;
  assign C_wy = cy_q;
  assign OVF  = ovf_q;
  assign Z    = z_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule
